// File: rtl/prog_mem.sv
// Program memory with a byte-stream loader.
// A loader streams a 16-bit word count (high byte first) and then count words
// (high byte first). The core is held until the load completes. After that the
// memory behaves as a single-port RAM with a registered, read-first read path.
// Optional feature macro: PROG_MEM_CHECKSUM_EN. When it is defined, the loader
// expects one trailing byte equal to the XOR of all preceding accepted bytes.
module prog_mem #(
  parameter int unsigned ADDR_W = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        we,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  output logic        ld_ready,
  output logic        core_hold,
  output logic        ld_err
);

  localparam int unsigned Depth  = 1 << ADDR_W;
  localparam logic [16:0] DepthW = 17'(Depth);

`ifdef PROG_MEM_CHECKSUM_EN
  typedef enum logic [2:0] {
    StCntHi, StCntLo, StDataHi, StDataLo, StChk, StRun
  } state_t;
  localparam state_t StTerm = StChk;
`else
  typedef enum logic [2:0] {
    StCntHi, StCntLo, StDataHi, StDataLo, StRun
  } state_t;
  localparam state_t StTerm = StRun;
`endif

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] ptr_q, ptr_d;
  logic [7:0]  hi_q, hi_d;
  logic        err_q, err_d;
  logic [15:0] rdata_q, rdata_d;
`ifdef PROG_MEM_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic [15:0] mem [Depth];

  logic              accept;
  logic              ld_wr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [15:0]       mem_wdata;
  logic [15:0]       new_count;
  logic              unused_addr;

  // Address bits above ADDR_W are deliberately ignored.
  assign unused_addr = ^addr[15:ADDR_W];

  assign ld_ready  = (state_q != StRun);
  assign core_hold = ld_ready;
  assign ld_err    = err_q;
  assign rdata     = rdata_q;
  assign accept    = ld_valid & ld_ready;
  assign new_count = {count_q[15:8], ld_byte};

  // Loader next-state: capture count, then stream words into memory.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    hi_d    = hi_q;
    err_d   = err_q;
    ld_wr   = 1'b0;
    if (accept) begin
      unique case (state_q)
        StCntHi: begin
          count_d = {ld_byte, 8'h00};
          state_d = StCntLo;
        end
        StCntLo: begin
          count_d = new_count;
          ptr_d   = 16'h0000;
          if ({1'b0, new_count} > DepthW) err_d = 1'b1;
          state_d = (new_count == 16'h0000) ? StTerm : StDataHi;
        end
        StDataHi: begin
          hi_d    = ld_byte;
          state_d = StDataLo;
        end
        StDataLo: begin
          // Words past the end of memory are consumed but dropped, never wrapped.
          ld_wr   = ({1'b0, ptr_q} < DepthW);
          ptr_d   = ptr_q + 16'd1;
          state_d = (ptr_q == count_q - 16'd1) ? StTerm : StDataHi;
        end
`ifdef PROG_MEM_CHECKSUM_EN
        StChk: begin
          if (ld_byte != csum_q) err_d = 1'b1;
          state_d = StRun;
        end
`endif
        default: state_d = state_q;
      endcase
    end
  end

`ifdef PROG_MEM_CHECKSUM_EN
  // Running XOR of every accepted byte except the checksum byte itself.
  always_comb begin
    csum_d = csum_q;
    if (accept && state_q != StChk) csum_d = csum_q ^ ld_byte;
  end
`endif

  // Single write port shared by the loader and the core (core only in RUN).
  always_comb begin
    mem_we    = rst & (ld_wr | ((state_q == StRun) & we));
    mem_waddr = ld_wr ? ptr_q[ADDR_W-1:0] : addr[ADDR_W-1:0];
    mem_wdata = ld_wr ? {hi_q, ld_byte} : wdata;
  end

  // Registered read data; forced to zero until the program is loaded.
  always_comb begin
    rdata_d = 16'h0000;
    if (state_q == StRun) rdata_d = mem[addr[ADDR_W-1:0]];
  end

  // Loader and read-path state; reset abandons any load in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StCntHi;
      count_q <= 16'h0000;
      ptr_q   <= 16'h0000;
      hi_q    <= 8'h00;
      err_q   <= 1'b0;
      rdata_q <= 16'h0000;
`ifdef PROG_MEM_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
`ifdef PROG_MEM_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Storage array, not reset so a reload can keep untouched words.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem: a default-size instance and a 4-word instance
// sharing clock and reset.
module tb_prog_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  ld_byte = 8'h00;

  logic [15:0] addr = 16'h0, wdata = 16'h0, rdata;
  logic        we = 1'b0, ld_valid = 1'b0, ld_ready, core_hold, ld_err;

  logic [15:0] addr_b = 16'h0, wdata_b = 16'h0, rdata_b;
  logic        we_b = 1'b0, ld_valid_b = 1'b0, ld_ready_b, core_hold_b, ld_err_b;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] d;

  always #5 clk = ~clk;

  prog_mem #(.ADDR_W(11)) dut (
    .clk(clk), .rst(rst), .addr(addr), .we(we), .wdata(wdata), .rdata(rdata),
    .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_ready(ld_ready),
    .core_hold(core_hold), .ld_err(ld_err)
  );

  prog_mem #(.ADDR_W(2)) dut_small (
    .clk(clk), .rst(rst), .addr(addr_b), .we(we_b), .wdata(wdata_b), .rdata(rdata_b),
    .ld_valid(ld_valid_b), .ld_byte(ld_byte), .ld_ready(ld_ready_b),
    .core_hold(core_hold_b), .ld_err(ld_err_b)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input bit to_b, input logic [7:0] b);
    @(negedge clk);
    if (to_b) ld_valid_b = 1'b1;
    else      ld_valid   = 1'b1;
    ld_byte = b;
    @(negedge clk);
    ld_valid   = 1'b0;
    ld_valid_b = 1'b0;
  endtask

  task automatic read_word(input bit to_b, input logic [15:0] a, output logic [15:0] q);
    @(negedge clk);
    if (to_b) addr_b = a;
    else      addr   = a;
    @(negedge clk);
    q = to_b ? rdata_b : rdata;
  endtask

  task automatic write_word(input logic [15:0] a, input logic [15:0] v);
    @(negedge clk);
    addr = a; wdata = v; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // Reset values
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_ld_ready", {15'h0, ld_ready}, 16'h1);
    check_eq("rst_core_hold", {15'h0, core_hold}, 16'h1);
    check_eq("rst_rdata", rdata, 16'h0000);
    check_eq("rst_ld_err", {15'h0, ld_err}, 16'h0);
    check_eq("rst_small_hold", {15'h0, core_hold_b}, 16'h1);
    rst = 1'b1;

    // Core write/read ignored before load
    @(negedge clk);
    addr = 16'h0; wdata = 16'hFFFF; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    check_eq("preload_rdata_zero", rdata, 16'h0000);

    // Basic two-word load
    send_byte(0, 8'h00); send_byte(0, 8'h02);
    send_byte(0, 8'hC1); send_byte(0, 8'h2A); send_byte(0, 8'h08);
    check_eq("load_a_hold_mid", {15'h0, core_hold}, 16'h1);
    send_byte(0, 8'h01);
`ifdef PROG_MEM_CHECKSUM_EN
    check_eq("load_a_hold_pre_chk", {15'h0, core_hold}, 16'h1);
    send_byte(0, 8'hE0);
`endif
    check_eq("load_a_hold_done", {15'h0, core_hold}, 16'h0);
    check_eq("load_a_ready_done", {15'h0, ld_ready}, 16'h0);
    check_eq("load_a_err", {15'h0, ld_err}, 16'h0);
    read_word(0, 16'h0000, d); check_eq("load_a_mem0", d, 16'hC12A);
    read_word(0, 16'h0001, d); check_eq("load_a_mem1", d, 16'h0801);
    // Upper address bits ignored: 0x8001 aliases word 1
    read_word(0, 16'h8001, d); check_eq("addr_upper_ignored", d, 16'h0801);

    // Core write then read, then read-first collision
    write_word(16'h0005, 16'h1234);
    read_word(0, 16'h0005, d); check_eq("run_wr_rd", d, 16'h1234);
    @(negedge clk);
    addr = 16'h0005; wdata = 16'h5678; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    check_eq("read_first_old", rdata, 16'h1234);
    @(negedge clk);
    check_eq("read_after_write", rdata, 16'h5678);

    // Loader bytes ignored in RUN
    send_byte(0, 8'h00);
    check_eq("run_ld_ready_low", {15'h0, ld_ready}, 16'h0);
    send_byte(0, 8'h01);
    check_eq("run_hold_low", {15'h0, core_hold}, 16'h0);
    read_word(0, 16'h0000, d); check_eq("run_ld_ignored_mem0", d, 16'hC12A);

    // Zero-count load; memory survives reset
    pulse_reset();
    check_eq("reset_rdata_zero", rdata, 16'h0000);
    check_eq("reset_hold", {15'h0, core_hold}, 16'h1);
    send_byte(0, 8'h00);
    check_eq("zero_cnt_hold_mid", {15'h0, core_hold}, 16'h1);
    send_byte(0, 8'h00);
`ifdef PROG_MEM_CHECKSUM_EN
    check_eq("zero_cnt_hold_pre_chk", {15'h0, core_hold}, 16'h1);
    send_byte(0, 8'h00);
`endif
    check_eq("zero_cnt_hold_done", {15'h0, core_hold}, 16'h0);
    check_eq("zero_cnt_err", {15'h0, ld_err}, 16'h0);
    read_word(0, 16'h0005, d); check_eq("mem_kept_5", d, 16'h5678);
    read_word(0, 16'h0000, d); check_eq("mem_kept_0", d, 16'hC12A);

    // Reset mid-load, then a fresh load
    pulse_reset();
    send_byte(0, 8'h00); send_byte(0, 8'h02); send_byte(0, 8'h11);
    pulse_reset();
    check_eq("midload_reset_hold", {15'h0, core_hold}, 16'h1);
    send_byte(0, 8'h00);
    check_eq("reload_hold_1", {15'h0, core_hold}, 16'h1);
    send_byte(0, 8'h01);
    check_eq("reload_hold_2", {15'h0, core_hold}, 16'h1);
    send_byte(0, 8'hBE);
    check_eq("reload_hold_3", {15'h0, core_hold}, 16'h1);
    send_byte(0, 8'hEF);
`ifdef PROG_MEM_CHECKSUM_EN
    check_eq("reload_hold_4", {15'h0, core_hold}, 16'h1);
    send_byte(0, 8'h50);
`endif
    check_eq("reload_hold_done", {15'h0, core_hold}, 16'h0);
    check_eq("reload_err", {15'h0, ld_err}, 16'h0);
    read_word(0, 16'h0000, d); check_eq("reload_mem0", d, 16'hBEEF);
    read_word(0, 16'h0001, d); check_eq("reload_mem1_kept", d, 16'h0801);

`ifdef PROG_MEM_CHECKSUM_EN
    // Wrong checksum: error flagged, RUN still entered
    pulse_reset();
    send_byte(0, 8'h00); send_byte(0, 8'h01); send_byte(0, 8'h12); send_byte(0, 8'h34);
    send_byte(0, 8'h00);
    check_eq("bad_chk_err", {15'h0, ld_err}, 16'h1);
    check_eq("bad_chk_hold", {15'h0, core_hold}, 16'h0);
    send_byte(0, 8'hAA);
    check_eq("bad_chk_ready", {15'h0, ld_ready}, 16'h0);
    read_word(0, 16'h0000, d); check_eq("bad_chk_mem0", d, 16'h1234);
`endif

    // Oversized count into the 4-word instance
    send_byte(1, 8'h00); send_byte(1, 8'h05);
    check_eq("ovf_err_early", {15'h0, ld_err_b}, 16'h1);
    send_byte(1, 8'h11); send_byte(1, 8'h11);
    send_byte(1, 8'h22); send_byte(1, 8'h22);
    send_byte(1, 8'h33); send_byte(1, 8'h33);
    send_byte(1, 8'h44); send_byte(1, 8'h44);
    send_byte(1, 8'h55);
    check_eq("ovf_hold_mid", {15'h0, core_hold_b}, 16'h1);
    send_byte(1, 8'h55);
`ifdef PROG_MEM_CHECKSUM_EN
    send_byte(1, 8'h05);
`endif
    check_eq("ovf_hold_done", {15'h0, core_hold_b}, 16'h0);
    check_eq("ovf_err", {15'h0, ld_err_b}, 16'h1);
    read_word(1, 16'h0000, d); check_eq("ovf_mem0", d, 16'h1111);
    read_word(1, 16'h0001, d); check_eq("ovf_mem1", d, 16'h2222);
    read_word(1, 16'h0002, d); check_eq("ovf_mem2", d, 16'h3333);
    read_word(1, 16'h0003, d); check_eq("ovf_mem3", d, 16'h4444);
    // Address 4 aliases 0; a wrapped fifth word would show 5555 here
    read_word(1, 16'h0004, d); check_eq("ovf_no_wrap", d, 16'h1111);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
